// File: rtl/mux_nch_pkg.sv
// mux_nch_pkg: shared types and helpers for the N-channel scan multiplexer.
//   mode_e        - registered operating mode (direct select / round-robin scan)
//   sel_width(n)  - select/pointer width, max(1, clog2(n))
//   next_unmasked - cyclic search for the next unmasked channel after ptr;
//                   only referenced when MUX_NCH_SCAN_CHMASK_EN is defined
package mux_nch_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Upper bound on channel count; sizes the mask vector seen by the helpers.
  localparam int MAX_CH = 64;

  function automatic int sel_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Returns the first channel strictly after ptr (wrapping modulo n) whose
  // mask bit is clear. If every other channel is masked, ptr is returned,
  // so a fully masked set leaves the pointer where it is.
  function automatic int next_unmasked(input int ptr, input logic [MAX_CH-1:0] mask,
                                       input int n);
    int   idx;
    int   res;
    logic found;
    res   = ptr;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      idx = ptr + i;
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if ((i <= n) && !found && !mask[idx[5:0]]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        res   = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_nch_scan_ptr.sv
// scan_ptr: round-robin channel pointer with per-channel dwell counter.
//   Owns the registered mode, the direct-to-scan pointer load and (with
//   MUX_NCH_SCAN_CHMASK_EN defined) the masked-channel skip.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_en         cycle enable; low freezes all state
//   i_mode       requested mode (0 direct, 1 scan)
//   i_sel        direct select, loaded into the pointer on entering scan
//   i_mask       channel mask (only with MUX_NCH_SCAN_CHMASK_EN)
//   o_ptr        channel presented this cycle when i_mode = 1
//   o_ptr_ok     o_ptr is presentable (in range and unmasked)
module scan_ptr
  import mux_nch_pkg::*;
#(
  parameter int  N_CH  = 8,
  parameter int  DWELL = 4,
  localparam int SW    = sel_width(N_CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_mode,
  input  logic [SW-1:0] i_sel,
`ifdef MUX_NCH_SCAN_CHMASK_EN
  input  logic [N_CH-1:0] i_mask,
`endif
  output logic [SW-1:0] o_ptr,
  output logic          o_ptr_ok
);

  localparam int            DW         = $clog2(DWELL) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SW-1:0] LAST_CH    = SW'(N_CH - 1);

  logic [SW-1:0] r_ptr;
  logic [DW-1:0] r_dwell;
  mode_e         r_mode;

  logic [SW-1:0] w_load_raw;
  logic [SW-1:0] w_load;
  logic [SW-1:0] w_cur;
  logic [DW-1:0] w_base;
  logic          w_cur_ok;
  logic [SW-1:0] w_adv;
  logic [SW-1:0] w_ptr_nxt;
  logic [DW-1:0] w_dwell_nxt;
  mode_e         w_mode_nxt;

`ifdef MUX_NCH_SCAN_CHMASK_EN
  logic [MAX_CH-1:0] w_mask64;
  assign w_mask64 = MAX_CH'(i_mask);
`endif

  // Pointer value used when entering scan: sel_i, or 0 when out of range.
  always_comb begin
    if (int'(i_sel) < N_CH) begin
      w_load_raw = i_sel;
    end else begin
      w_load_raw = {SW{1'b0}};
    end
`ifdef MUX_NCH_SCAN_CHMASK_EN
    if (w_mask64[6'(w_load_raw)]) begin
      w_load = SW'(next_unmasked(int'(w_load_raw), w_mask64, N_CH));
    end else begin
      w_load = w_load_raw;
    end
`else
    w_load = w_load_raw;
`endif
  end

  // Current channel, dwell step, pointer advance and mode update.
  always_comb begin
    w_cur       = r_ptr;
    w_base      = r_dwell;
    w_ptr_nxt   = r_ptr;
    w_dwell_nxt = r_dwell;
    w_mode_nxt  = r_mode;
    // Entering scan presents the loaded channel in the same cycle and counts
    // that cycle as the first dwell cycle, so it is shown DWELL times.
    if (i_mode && (r_mode == MODE_DIRECT)) begin
      w_cur  = w_load;
      w_base = {DW{1'b0}};
    end else begin
      w_cur  = r_ptr;
      w_base = r_dwell;
    end
`ifdef MUX_NCH_SCAN_CHMASK_EN
    w_cur_ok = !w_mask64[6'(w_cur)];
    w_adv    = SW'(next_unmasked(int'(w_cur), w_mask64, N_CH));
`else
    w_cur_ok = 1'b1;
    if (w_cur == LAST_CH) begin
      w_adv = {SW{1'b0}};
    end else begin
      w_adv = w_cur + {{(SW-1){1'b0}}, 1'b1};
    end
`endif
    if (i_en) begin
      if (i_mode) begin
        w_mode_nxt = MODE_SCAN;
        if (!w_cur_ok) begin
          // Pointer landed on a masked channel: jump on and restart dwell.
          w_ptr_nxt   = w_adv;
          w_dwell_nxt = {DW{1'b0}};
        end else if (w_base == DWELL_LAST) begin
          w_ptr_nxt   = w_adv;
          w_dwell_nxt = {DW{1'b0}};
        end else begin
          w_ptr_nxt   = w_cur;
          w_dwell_nxt = w_base + {{(DW-1){1'b0}}, 1'b1};
        end
      end else begin
        // Leaving scan freezes pointer and dwell where they are.
        w_mode_nxt = MODE_DIRECT;
      end
    end else begin
      w_mode_nxt = r_mode;
    end
  end

  // Pointer, dwell and mode state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= {SW{1'b0}};
      r_dwell <= {DW{1'b0}};
      r_mode  <= MODE_DIRECT;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_dwell <= w_dwell_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  assign o_ptr    = w_cur;
  assign o_ptr_ok = w_cur_ok;

endmodule

// File: rtl/mux_nch_scan.sv
// mux_nch_scan: registered N_CH-channel, W-bit multiplexer with direct
// select and round-robin scan modes, plus valid flag and channel tag.
// Optional feature macro: MUX_NCH_SCAN_CHMASK_EN adds mask_i (bit k = 1
// masks channel k); without it every channel is unmasked.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   d_i         packed channel data, channel k at [k*W +: W]
//   sel_i       direct-mode select
//   mode_i      0 direct, 1 scan
//   en_i        cycle enable; low holds y_o/ch_o and drops vld_o
//   mask_i      channel mask (only with MUX_NCH_SCAN_CHMASK_EN)
//   y_o         registered selected data
//   ch_o        channel that produced y_o
//   vld_o       y_o/ch_o valid
module mux_nch_scan
  import mux_nch_pkg::*;
#(
  parameter int  N_CH  = 8,
  parameter int  W     = 4,
  parameter int  DWELL = 4,
  localparam int SW    = sel_width(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH*W-1:0] d_i,
  input  logic [SW-1:0]   sel_i,
  input  logic            mode_i,
  input  logic            en_i,
`ifdef MUX_NCH_SCAN_CHMASK_EN
  input  logic [N_CH-1:0] mask_i,
`endif
  output logic [W-1:0]    y_o,
  output logic [SW-1:0]   ch_o,
  output logic            vld_o
);

  logic [W-1:0]  r_y;
  logic [SW-1:0] r_ch;
  logic          r_vld;

  logic [SW-1:0] w_ptr;
  logic          w_ptr_ok;
  logic [SW-1:0] w_c;
  logic          w_c_ok;
  logic [W-1:0]  w_data;
  logic [W-1:0]  w_y_nxt;
  logic [SW-1:0] w_ch_nxt;
  logic          w_vld_nxt;

`ifdef MUX_NCH_SCAN_CHMASK_EN
  logic [MAX_CH-1:0] w_mask64;
  assign w_mask64 = MAX_CH'(mask_i);
`endif

  scan_ptr #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_scan_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (en_i),
    .i_mode   (mode_i),
    .i_sel    (sel_i),
`ifdef MUX_NCH_SCAN_CHMASK_EN
    .i_mask   (mask_i),
`endif
    .o_ptr    (w_ptr),
    .o_ptr_ok (w_ptr_ok)
  );

  // Channel decode: scan pointer or direct select, with its validity.
  always_comb begin
    if (mode_i) begin
      w_c    = w_ptr;
      w_c_ok = w_ptr_ok;
    end else begin
      w_c    = sel_i;
`ifdef MUX_NCH_SCAN_CHMASK_EN
      w_c_ok = (int'(sel_i) < N_CH) && !w_mask64[6'(sel_i)];
`else
      w_c_ok = (int'(sel_i) < N_CH);
`endif
    end
  end

  // AND-OR data mux; an out-of-range select yields zero.
  always_comb begin
    w_data = {W{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      w_data = w_data | ({W{int'(w_c) == k}} & d_i[k*W +: W]);
    end
  end

  // Next output values; a disabled cycle holds data/tag and drops valid.
  always_comb begin
    if (en_i) begin
      w_y_nxt   = w_c_ok ? w_data : {W{1'b0}};
      w_ch_nxt  = w_c;
      w_vld_nxt = w_c_ok;
    end else begin
      w_y_nxt   = r_y;
      w_ch_nxt  = r_ch;
      w_vld_nxt = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y   <= {W{1'b0}};
      r_ch  <= {SW{1'b0}};
      r_vld <= 1'b0;
    end else begin
      r_y   <= w_y_nxt;
      r_ch  <= w_ch_nxt;
      r_vld <= w_vld_nxt;
    end
  end

  assign y_o   = r_y;
  assign ch_o  = r_ch;
  assign vld_o = r_vld;

endmodule

// File: tb/tb_mux_nch_scan.sv
// tb_mux_nch_scan: directed-vector bench for mux_nch_scan.
//   dut_a: N_CH=8 W=4 DWELL=4, data ch k = k
//   dut_b: N_CH=8 W=4 DWELL=1, data ch k = k (mask tests with MUX_NCH_SCAN_CHMASK_EN)
//   dut_c: N_CH=6 W=4 DWELL=2, data ch k = 8+k
module tb_mux_nch_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [2:0] sel;

  logic [31:0] d_a = 32'h7654_3210;
  logic [31:0] d_b = 32'h7654_3210;
  logic [23:0] d_c = 24'hDC_BA98;

`ifdef MUX_NCH_SCAN_CHMASK_EN
  logic [7:0] mask_a = 8'h00;
  logic [7:0] mask_b = 8'h00;
  logic [5:0] mask_c = 6'h00;
`endif

  logic [3:0] y_a, y_b, y_c;
  logic [2:0] ch_a, ch_b, ch_c;
  logic       v_a, v_b, v_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_nch_scan #(.N_CH(8), .W(4), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .d_i(d_a), .sel_i(sel), .mode_i(mode), .en_i(en),
`ifdef MUX_NCH_SCAN_CHMASK_EN
    .mask_i(mask_a),
`endif
    .y_o(y_a), .ch_o(ch_a), .vld_o(v_a)
  );

  mux_nch_scan #(.N_CH(8), .W(4), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .d_i(d_b), .sel_i(sel), .mode_i(mode), .en_i(en),
`ifdef MUX_NCH_SCAN_CHMASK_EN
    .mask_i(mask_b),
`endif
    .y_o(y_b), .ch_o(ch_b), .vld_o(v_b)
  );

  mux_nch_scan #(.N_CH(6), .W(4), .DWELL(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .d_i(d_c), .sel_i(sel), .mode_i(mode), .en_i(en),
`ifdef MUX_NCH_SCAN_CHMASK_EN
    .mask_i(mask_c),
`endif
    .y_o(y_c), .ch_o(ch_c), .vld_o(v_c)
  );

  logic [31:0] obs_a, obs_b, obs_c;
  assign obs_a = {24'h0, v_a, ch_a, y_a};
  assign obs_b = {24'h0, v_b, ch_b, y_b};
  assign obs_c = {24'h0, v_c, ch_c, y_c};

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Packs the expected {vld, ch, y} the same way the obs_* buses are built.
  function automatic logic [31:0] pk(input logic v, input int ch, input int y);
    logic [2:0] c3;
    logic [3:0] y4;
    c3 = ch[2:0];
    y4 = y[3:0];
    return {24'h0, v, c3, y4};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 1'b0;
    sel   = 3'd0;
    step();
    step();
    chk_vec("rst_a", obs_a, pk(1'b0, 0, 0));
    chk_vec("rst_b", obs_b, pk(1'b0, 0, 0));
    chk_vec("rst_c", obs_c, pk(1'b0, 0, 0));

    // Scan from reset: entering scan loads sel=0.
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = 1'b1;
    for (int i = 0; i < 54; i++) begin
      step();
      chk_vec("scan_a", obs_a, pk(1'b1, (i / 4) % 8, (i / 4) % 8));
      chk_vec("scan_b", obs_b, pk(1'b1, i % 8, i % 8));
      chk_vec("scan_c", obs_c, pk(1'b1, (i / 2) % 6, 8 + (i / 2) % 6));
    end

    // dut_a is presenting channel 5; asynchronous reset clears at once.
    rst_n = 1'b0;
    #1;
    chk_vec("rst_mid_a", obs_a, pk(1'b0, 0, 0));
    chk_vec("rst_mid_c", obs_c, pk(1'b0, 0, 0));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_vec("restart_a", obs_a, pk(1'b1, i / 4, i / 4));
    end

    // Direct mode, including out-of-range selects on the 6-channel part.
    mode = 1'b0;
    sel  = 3'd3;
    step();
    chk_vec("dir3_a", obs_a, pk(1'b1, 3, 3));
    chk_vec("dir3_c", obs_c, pk(1'b1, 3, 11));
    sel = 3'd7;
    step();
    chk_vec("dir7_a", obs_a, pk(1'b1, 7, 7));
    chk_vec("dir7_c", obs_c, pk(1'b0, 7, 0));
    sel = 3'd6;
    step();
    chk_vec("dir6_c", obs_c, pk(1'b0, 6, 0));

    // Direct sel=2, then scan: channel 2 with a fresh dwell.
    sel = 3'd2;
    step();
    chk_vec("dir2_a", obs_a, pk(1'b1, 2, 2));
    mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_vec("d2s_a", obs_a, pk(1'b1, 2, 2));
    end
    // Disabled cycles: mode/sel changes must be ignored.
    en   = 1'b0;
    mode = 1'b0;
    sel  = 3'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_vec("hold_a", obs_a, pk(1'b0, 2, 2));
    end
    en   = 1'b1;
    mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_vec("resume_a", obs_a, pk(1'b1, (i < 2) ? 2 : 3, (i < 2) ? 2 : 3));
    end

    // Entering scan with an out-of-range select loads channel 0.
    mode = 1'b0;
    sel  = 3'd7;
    step();
    mode = 1'b1;
    step();
    chk_vec("load_oor_c", obs_c, pk(1'b1, 0, 8));
    chk_vec("load7_a", obs_a, pk(1'b1, 7, 7));

`ifdef MUX_NCH_SCAN_CHMASK_EN
    begin
      int seq [6] = '{0, 3, 4, 6, 7, 0};
      mode   = 1'b0;
      sel    = 3'd0;
      mask_b = 8'b0010_0110;
      step();
      mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step();
        chk_vec("mask_seq_b", obs_b, pk(1'b1, seq[i], seq[i]));
      end
      mode = 1'b0;
      sel  = 3'd1;
      step();
      chk_vec("mask_dir_b", obs_b, pk(1'b0, 1, 0));
      mask_b = 8'hFF;
      mode   = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        chk_vec("all_masked_b", {28'h0, v_b, ch_b}, {28'h0, 1'b0, 3'd1});
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
